// File: rtl/aes_subbyte_ctrl.sv
// SubBytes handshake initiator. It runs one op at a time: accept a state word, pulse
// sub_start, wait for sub_ready or a timeout, then hold the result until downstream accepts it.
module aes_subbyte_ctrl #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_en_de,
    output logic              sub_start,
    output logic              sub_en_de,
    output logic [DATA_W-1:0] sub_data_in,
    input  logic              sub_ready,
    input  logic [DATA_W-1:0] sub_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sub_data_q, sub_data_d;
    logic              en_de_q, en_de_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [CNT_W-1:0]  done_q, done_d;
    logic [CNT_W-1:0]  err_q, err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        sub_data_d = sub_data_q;
        en_de_d    = en_de_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        tmo_d      = tmo_q;
        done_d     = done_q;
        err_d      = err_q;
        in_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sub_data_d = in_data;
                    en_de_d    = in_en_de;
                    state_d    = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // A response landing on the timeout cycle still counts as a success.
                if (sub_ready) begin
                    out_data_d = sub_data_out;
                    out_err_d  = 1'b0;
                    done_d     = (done_q == '1) ? done_q : done_q + CNT_W'(1);
                    state_d    = HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    err_d      = (err_q == '1) ? err_q : err_q + CNT_W'(1);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // The output handshake cycle can also accept the next word.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        sub_data_d = in_data;
                        en_de_d    = in_en_de;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            // NOTE: the wide data registers are reset as well, because their values are visible at the ports.
            sub_data_q <= '0;
            en_de_q    <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            tmo_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only.
            state_q    <= state_d;
            sub_data_q <= sub_data_d;
            en_de_q    <= en_de_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign sub_start   = (state_q == START);
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign sub_data_in = sub_data_q;
    assign sub_en_de   = en_de_q;
    assign out_data    = out_data_q;
    assign out_err     = out_err_q;
    assign done_cnt    = done_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_aes_subbyte_ctrl.sv
// Directed bench for aes_subbyte_ctrl. A SubBytes stub answers k cycles after each
// sub_start; a short timeout and 2-bit counters keep the edge cases reachable.
module tb_aes_subbyte_ctrl;

    localparam int DW  = 128;
    localparam int TMO = 8;
    localparam int CW  = 2;

    localparam logic [DW-1:0] D1 = 128'h11223344_00000000_00000000_12345678;
    localparam logic [DW-1:0] R1 = 128'h8293c31b_63636363_63636363_c918b1bc;
    localparam logic [DW-1:0] D2 = 128'hdeadbeef_00112233_44556677_8899aabb;
    localparam logic [DW-1:0] D3 = 128'h00000000_00000000_00000000_00000001;
    localparam logic [DW-1:0] R3 = 128'h63636363_63636363_63636363_6363637c;
    localparam logic [DW-1:0] D4 = 128'h01010101_01010101_01010101_01010101;
    localparam logic [DW-1:0] R4 = 128'h7c7c7c7c_7c7c7c7c_7c7c7c7c_7c7c7c7c;
    localparam logic [DW-1:0] D5 = 128'h55555555_55555555_55555555_55555555;
    localparam logic [DW-1:0] R5 = 128'hfcfcfcfc_fcfcfcfc_fcfcfcfc_fcfcfcfc;
    localparam logic [DW-1:0] D6 = 128'h53535353_53535353_53535353_53535353;
    localparam logic [DW-1:0] R6 = 128'hedededed_edededed_edededed_edededed;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_en_de = 1'b0;
    logic          sub_start;
    logic          sub_en_de;
    logic [DW-1:0] sub_data_in;
    logic          sub_ready = 1'b0;
    logic [DW-1:0] sub_data_out = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic          busy;
    logic [CW-1:0] done_cnt;
    logic [CW-1:0] err_cnt;

    aes_subbyte_ctrl #(.DATA_W(DW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_en_de(in_en_de),
        .sub_start(sub_start), .sub_en_de(sub_en_de), .sub_data_in(sub_data_in),
        .sub_ready(sub_ready), .sub_data_out(sub_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stub: answers stub_k cycles after sub_start (0 means never); also counts pulses.
    int            stub_k   = 0;
    logic [DW-1:0] stub_res = '0;
    int            stub_cnt = 0;
    int            starts   = 0;
    int            spur_req = 0;
    int            spur_ack = 0;

    always @(negedge clk) begin
        sub_ready    = 1'b0;
        sub_data_out = '0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                sub_ready    = 1'b1;
                sub_data_out = stub_res;
            end
        end
        if (spur_req != spur_ack) begin
            spur_ack     = spur_req;
            sub_ready    = 1'b1;
            sub_data_out = stub_res;
        end
        if (sub_start === 1'b1) begin
            starts++;
            if (stub_k > 0) stub_cnt = stub_k;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4 * TMO) begin
            tick();
            lat++;
        end
    endtask

    // Called in an IDLE cycle. Returns in the first cycle that has out_valid high.
    task automatic start_op(input string tag, input logic [DW-1:0] d, input logic ed,
                            input int k, input logic [DW-1:0] res, input int exp_lat);
        int lat;
        stub_k   = k;
        stub_res = res;
        in_valid = 1'b1;
        in_data  = d;
        in_en_de = ed;
        #1;
        check({tag, "_in_ready_idle"}, DW'(in_ready), DW'(1));
        tick();
        in_valid = 1'b0;
        check({tag, "_sub_start"}, DW'(sub_start), DW'(1));
        check({tag, "_sub_data_in"}, sub_data_in, d);
        check({tag, "_sub_en_de"}, DW'(sub_en_de), DW'(ed));
        wait_valid(lat);
        check({tag, "_latency"}, DW'(lat), DW'(exp_lat));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready_hs"}, DW'(in_ready), DW'(1));
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, DW'(out_valid), DW'(0));
        check({tag, "_idle_busy"}, DW'(busy), DW'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int lat;
        int exp_done;
        bit saw_valid;

        // Reset state
        tick();
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_sub_start", DW'(sub_start), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(1));
        check("rst_out_err", DW'(out_err), DW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_sub_data_in", sub_data_in, '0);
        check("rst_sub_en_de", DW'(sub_en_de), DW'(0));
        check("rst_done", DW'(done_cnt), DW'(0));
        check("rst_err", DW'(err_cnt), DW'(0));
        rst = 1'b0;
        tick();

        // T1: normal op, response 3 cycles after sub_start
        s0 = starts;
        start_op("t1", D1, 1'b1, 3, R1, 4);
        check("t1_out_data", out_data, R1);
        check("t1_out_err", DW'(out_err), DW'(0));
        check("t1_done", DW'(done_cnt), DW'(1));
        check("t1_err", DW'(err_cnt), DW'(0));
        check("t1_one_start", DW'(starts - s0), DW'(1));
        release_out("t1");

        // T2: timeout, no response at all
        do_reset();
        start_op("t2", D2, 1'b0, 0, '0, TMO + 1);
        check("t2_out_data", out_data, '0);
        check("t2_out_err", DW'(out_err), DW'(1));
        check("t2_err", DW'(err_cnt), DW'(1));
        check("t2_done", DW'(done_cnt), DW'(0));

        // T3: backpressure in HOLD with a pending input word
        s0 = starts;
        in_valid = 1'b1;
        in_data  = D3;
        in_en_de = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("t3_valid", DW'(out_valid), DW'(1));
            check("t3_data", out_data, '0);
            check("t3_err", DW'(out_err), DW'(1));
            check("t3_in_ready", DW'(in_ready), DW'(0));
            check("t3_sub_start", DW'(sub_start), DW'(0));
            check("t3_busy", DW'(busy), DW'(1));
            tick();
        end
        check("t3_no_starts", DW'(starts - s0), DW'(0));

        // T4: back-to-back, next word accepted on the output handshake
        stub_k    = 2;
        stub_res  = R3;
        out_ready = 1'b1;
        #1;
        check("t4_in_ready_hs", DW'(in_ready), DW'(1));
        tick();
        check("t4a_sub_start", DW'(sub_start), DW'(1));
        check("t4a_sub_data_in", sub_data_in, D3);
        check("t4a_out_valid", DW'(out_valid), DW'(0));
        in_data  = D4;
        in_en_de = 1'b1;
        wait_valid(lat);
        check("t4a_latency", DW'(lat), DW'(3));
        check("t4a_out_data", out_data, R3);
        check("t4a_out_err", DW'(out_err), DW'(0));
        check("t4a_in_ready", DW'(in_ready), DW'(1));
        stub_k   = 1;
        stub_res = R4;
        tick();
        check("t4b_sub_start", DW'(sub_start), DW'(1));
        check("t4b_sub_data_in", sub_data_in, D4);
        check("t4b_sub_en_de", DW'(sub_en_de), DW'(1));
        check("t4b_busy", DW'(busy), DW'(1));
        in_valid = 1'b0;
        wait_valid(lat);
        check("t4b_latency", DW'(lat), DW'(2));
        check("t4b_out_data", out_data, R4);
        check("t4b_done", DW'(done_cnt), DW'(2));
        check("t4b_err", DW'(err_cnt), DW'(1));
        tick();
        out_ready = 1'b0;
        check("t4_idle_busy", DW'(busy), DW'(0));
        check("t4_idle_valid", DW'(out_valid), DW'(0));

        // T5: reset two cycles after sub_start, later response ignored
        stub_k   = 5;
        stub_res = R5;
        in_valid = 1'b1;
        in_data  = D5;
        tick();
        in_valid = 1'b0;
        check("t5_sub_start", DW'(sub_start), DW'(1));
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_busy", DW'(busy), DW'(0));
        check("t5_out_valid", DW'(out_valid), DW'(0));
        check("t5_sub_start_low", DW'(sub_start), DW'(0));
        check("t5_done", DW'(done_cnt), DW'(0));
        check("t5_err", DW'(err_cnt), DW'(0));
        check("t5_sub_data_in", sub_data_in, '0);
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
        end
        check("t5_late_ready_ignored", DW'(saw_valid), DW'(0));
        check("t5_done_after", DW'(done_cnt), DW'(0));

        // T6: response on the timeout cycle wins; one cycle later is a timeout
        start_op("t6a", D6, 1'b1, TMO, R6, TMO + 1);
        check("t6a_out_err", DW'(out_err), DW'(0));
        check("t6a_out_data", out_data, R6);
        check("t6a_done", DW'(done_cnt), DW'(1));
        check("t6a_err", DW'(err_cnt), DW'(0));
        release_out("t6a");
        start_op("t6b", D6, 1'b0, TMO + 1, R6, TMO + 1);
        check("t6b_out_err", DW'(out_err), DW'(1));
        tick();
        tick();
        check("t6b_out_data_stable", out_data, '0);
        check("t6b_done", DW'(done_cnt), DW'(1));
        check("t6b_err", DW'(err_cnt), DW'(1));
        release_out("t6b");

        // Spurious sub_ready in IDLE
        s0 = starts;
        spur_req++;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
        end
        check("spur_no_valid", DW'(saw_valid), DW'(0));
        check("spur_done", DW'(done_cnt), DW'(1));
        check("spur_no_start", DW'(starts - s0), DW'(0));

        // Saturation of the 2-bit done counter
        exp_done = 1;
        for (int i = 0; i < 3; i++) begin
            start_op("sat", D1, 1'b0, 1, R1, 2);
            exp_done = (exp_done == 3) ? 3 : exp_done + 1;
            check("sat_done", DW'(done_cnt), DW'(exp_done));
            check("sat_err", DW'(err_cnt), DW'(1));
            release_out("sat");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
